// File: rtl/mult_accumulator_pkg.sv
// rtl/mult_accumulator_pkg.sv - shared state encoding and default widths for mult_accumulator
package mult_accumulator_pkg;

  localparam int DEF_N     = 8;
  localparam int DEF_ACC_W = 24;
  localparam int DEF_LEN_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mult_accumulator_array_mult.sv
// rtl/mult_accumulator_array_mult.sv - combinational unsigned array multiplier
module array_mult #(
  parameter int N = 8
) (
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic [2*N-1:0] p_o
);

  // Sum of shifted partial products, one row per bit of b_i.
  always_comb begin
    p_o = '0;
    for (int i = 0; i < N; i++) begin
      if (b_i[i]) begin
        p_o = p_o + ((2*N)'(a_i) << i);
      end
    end
  end

endmodule

// File: rtl/mult_accumulator.sv
// rtl/mult_accumulator.sv - registered-operand multiply-accumulate with valid/ready in and out
module mult_accumulator
  import mult_accumulator_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int ACC_W = DEF_ACC_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow,
  output logic             busy
);

  state_e             state_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [ACC_W-1:0]   acc_q;
  logic               ovf_q;
  logic               s1_valid_q;
  logic [N-1:0]       a_q;
  logic [N-1:0]       b_q;

  logic [2*N-1:0]     prod;
  logic [ACC_W:0]     acc_sum_d;
  logic               xfer;

  array_mult #(.N(N)) u_mult (
    .a_i (a_q),
    .b_i (b_q),
    .p_o (prod)
  );

  // One extra bit on the sum captures the carry out of the accumulator MSB.
  assign acc_sum_d = {1'b0, acc_q} + (ACC_W+1)'(prod);

  assign in_ready  = (state_q == ST_RUN) && (cnt_q < len_q);
  assign xfer      = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign acc_out   = acc_q;
  assign overflow  = ovf_q;

  // Job controller, stage-1 operand registers and accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
    end else begin
      s1_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_q   <= len;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= (len == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (xfer) begin
            a_q        <= a;
            b_q        <= b;
            s1_valid_q <= 1'b1;
            cnt_q      <= cnt_q + 1'b1;
          end
          // Stage-1 holding the len-th pair means this accumulate closes the job.
          if (s1_valid_q) begin
            acc_q <= acc_sum_d[ACC_W-1:0];
            if (acc_sum_d[ACC_W]) begin
              ovf_q <= 1'b1;
            end
            if (cnt_q == len_q) begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
